dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data RAM between the pipeline MEM stage (port 0) and a secondary master such as a program loader or debug port (port 1). It grants at most one access per cycle and drives the RAM command bus. It registers read data back to the winning requester and stalls the pipeline when the CPU loses arbitration. A starvation counter guarantees port 1 forward progress under continuous CPU traffic. It sits between the MEM stage / loader and the data RAM.

---
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-RAM arbiter: the CPU MEM stage (port 0) has priority over a
// secondary master (port 1). A starvation counter guarantees that port 1
// eventually wins. Read data is registered back to the port that issued the load.
module dmem_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  Req_0,
    input  logic                  Write_0,
    input  logic [DATA_WIDTH-1:0] Addr_0,
    input  logic [DATA_WIDTH-1:0] Wdata_0,
    output logic                  Gnt_0,
    output logic                  Stall_0,
    output logic                  Rvalid_0,
    output logic [DATA_WIDTH-1:0] Rdata_0,

    input  logic                  Req_1,
    input  logic                  Write_1,
    input  logic [DATA_WIDTH-1:0] Addr_1,
    input  logic [DATA_WIDTH-1:0] Wdata_1,
    output logic                  Gnt_1,
    output logic                  Rvalid_1,
    output logic [DATA_WIDTH-1:0] Rdata_1,

    output logic                  Mem_Write_Enable,
    output logic                  Mem_Read_Enable,
    output logic [DATA_WIDTH-1:0] Mem_Address,
    output logic [DATA_WIDTH-1:0] Mem_Write_Data,
    input  logic [DATA_WIDTH-1:0] Mem_Read_Data
);

    localparam int unsigned WC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(STARVE_LIMIT);

    logic [WC_W-1:0]       wait_count;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0_q;
    logic                  rvalid1_q;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    // Pick at most one winner per cycle; port 1 only wins a conflict once starved.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (Req_0 && Req_1) begin
                if (wait_count == WC_MAX) gnt1 = 1'b1;
                else                      gnt0 = 1'b1;
            end else if (Req_0) begin
                gnt0 = 1'b1;
            end else if (Req_1) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Steer the winner's command onto the RAM bus; idle bus is all zeros.
    always_comb begin
        Mem_Write_Enable = 1'b0;
        Mem_Read_Enable  = 1'b0;
        Mem_Address      = '0;
        Mem_Write_Data   = '0;
        if (gnt0) begin
            Mem_Write_Enable = Write_0;
            Mem_Read_Enable  = ~Write_0;
            Mem_Address      = Addr_0;
            Mem_Write_Data   = Wdata_0;
        end else if (gnt1) begin
            Mem_Write_Enable = Write_1;
            Mem_Read_Enable  = ~Write_1;
            Mem_Address      = Addr_1;
            Mem_Write_Data   = Wdata_1;
        end
    end

    // Grant/stall outputs; read responses are hidden while reset is high so a
    // response in flight at reset assertion never reaches a requester.
    always_comb begin
        Gnt_0    = gnt0;
        Gnt_1    = gnt1;
        Stall_0  = Req_0 & ~gnt0;
        Rvalid_0 = rvalid0_q & ~reset;
        Rvalid_1 = rvalid1_q & ~reset;
        Rdata_0  = reset ? '0 : rdata0_q;
        Rdata_1  = reset ? '0 : rdata1_q;
    end

    // Count consecutive cycles port 1 waits; saturates at the starvation limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_count <= '0;
        end else if (!Req_1 || gnt1) begin
            wait_count <= '0;
        end else if (wait_count != WC_MAX) begin
            wait_count <= wait_count + WC_W'(1);
        end
    end

    // Capture load data for the winning port; valid pulses for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= gnt0 & ~Write_0;
            rvalid1_q <= gnt1 & ~Write_1;
            if (gnt0 && !Write_0) rdata0_q <= Mem_Read_Data;
            if (gnt1 && !Write_1) rdata1_q <= Mem_Read_Data;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed RAM model.
module tb_dmem_arbiter;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_0, write_0, req_1, write_1;
    logic [DW-1:0] addr_0, wdata_0, addr_1, wdata_1;
    logic          gnt_0, stall_0, rvalid_0, gnt_1, rvalid_1;
    logic [DW-1:0] rdata_0, rdata_1;
    logic          mem_we, mem_re;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

    logic [DW-1:0] ram [0:63];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .Req_0            (req_0),
        .Write_0          (write_0),
        .Addr_0           (addr_0),
        .Wdata_0          (wdata_0),
        .Gnt_0            (gnt_0),
        .Stall_0          (stall_0),
        .Rvalid_0         (rvalid_0),
        .Rdata_0          (rdata_0),
        .Req_1            (req_1),
        .Write_1          (write_1),
        .Addr_1           (addr_1),
        .Wdata_1          (wdata_1),
        .Gnt_1            (gnt_1),
        .Rvalid_1         (rvalid_1),
        .Rdata_1          (rdata_1),
        .Mem_Write_Enable (mem_we),
        .Mem_Read_Enable  (mem_re),
        .Mem_Address      (mem_addr),
        .Mem_Write_Data   (mem_wdata),
        .Mem_Read_Data    (mem_rdata)
    );

    // RAM model: combinational read, write at the edge ending the grant cycle.
    assign mem_rdata = ram[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = '0;
        reset = 1'b1;
        req_0 = 1'b1; write_0 = 1'b0; addr_0 = '0; wdata_0 = '0;
        req_1 = 1'b0; write_1 = 1'b0; addr_1 = '0; wdata_1 = '0;

        // Reset held two cycles with a pending CPU request
        tick();
        mid();
        check("rst_gnt0",   32'(gnt_0), 32'd0);
        check("rst_stall0", 32'(stall_0), 32'd1);
        check("rst_rvalid0", 32'(rvalid_0), 32'd0);
        check("rst_rvalid1", 32'(rvalid_1), 32'd0);
        check("rst_rdata0", rdata_0, 32'd0);
        check("rst_rdata1", rdata_1, 32'd0);
        check("rst_mwe",    32'(mem_we), 32'd0);
        check("rst_mre",    32'(mem_re), 32'd0);
        tick();
        mid();
        check("rst2_gnt0",  32'(gnt_0), 32'd0);

        // Release reset: CPU store granted in the same cycle
        tick();
        reset = 1'b0;
        write_0 = 1'b1; addr_0 = 32'h10; wdata_0 = 32'hDEADBEEF;
        mid();
        check("st_gnt0",   32'(gnt_0), 32'd1);
        check("st_stall0", 32'(stall_0), 32'd0);
        check("st_mwe",    32'(mem_we), 32'd1);
        check("st_mre",    32'(mem_re), 32'd0);
        check("st_maddr",  mem_addr, 32'h10);
        check("st_mwdata", mem_wdata, 32'hDEADBEEF);

        // Load the same address right after the store
        tick();
        write_0 = 1'b0;
        mid();
        check("ld_gnt0",   32'(gnt_0), 32'd1);
        check("ld_stall0", 32'(stall_0), 32'd0);
        check("ld_mre",    32'(mem_re), 32'd1);
        check("ld_norv_st", 32'(rvalid_0), 32'd0);
        tick();
        req_0 = 1'b0;
        mid();
        check("ld_rvalid0", 32'(rvalid_0), 32'd1);
        check("ld_rdata0",  rdata_0, 32'hDEADBEEF);
        check("idle_gnt0",  32'(gnt_0), 32'd0);
        check("idle_mre",   32'(mem_re), 32'd0);
        check("idle_maddr", mem_addr, 32'd0);
        check("idle_mwdata", mem_wdata, 32'd0);
        tick();
        mid();
        check("rv0_pulse",  32'(rvalid_0), 32'd0);
        check("rdata0_hold", rdata_0, 32'hDEADBEEF);

        // Lone port 1 request wins immediately
        tick();
        req_1 = 1'b1; addr_1 = 32'h40;
        mid();
        check("solo_gnt1",  32'(gnt_1), 32'd1);
        check("solo_maddr", mem_addr, 32'h40);
        tick();
        req_1 = 1'b0;
        mid();
        check("solo_rv1",   32'(rvalid_1), 32'd1);

        // Continuous contention: port 1 wins every fifth cycle
        tick();
        req_0 = 1'b1; addr_0 = 32'h10;
        req_1 = 1'b1; addr_1 = 32'h40;
        for (int i = 0; i < 10; i++) begin
            mid();
            check($sformatf("cont_gnt1_%0d", i), 32'(gnt_1), 32'((i % 5) == 4));
            check($sformatf("cont_gnt0_%0d", i), 32'(gnt_0), 32'((i % 5) != 4));
            check($sformatf("cont_stall_%0d", i), 32'(stall_0), 32'((i % 5) == 4));
            tick();
        end

        // Counter clears when port 1 drops its request for a cycle
        for (int i = 0; i < 8; i++) begin
            req_1 = (i != 2);
            mid();
            check($sformatf("clr_gnt1_%0d", i), 32'(gnt_1), 32'(i == 7));
            check($sformatf("clr_gnt0_%0d", i), 32'(gnt_0), 32'(i != 7));
            tick();
        end
        req_0 = 1'b0;
        req_1 = 1'b0;

        // Cross-port coherency: port 1 store, port 0 load of the same word
        tick();
        req_1 = 1'b1; write_1 = 1'b1; addr_1 = 32'h20; wdata_1 = 32'h12345678;
        mid();
        check("xp_gnt1", 32'(gnt_1), 32'd1);
        check("xp_mwe",  32'(mem_we), 32'd1);
        tick();
        req_1 = 1'b0;
        req_0 = 1'b1; write_0 = 1'b0; addr_0 = 32'h20;
        mid();
        check("xp_gnt0",    32'(gnt_0), 32'd1);
        check("xp_norv1_st", 32'(rvalid_1), 32'd0);
        tick();
        req_0 = 1'b0;
        mid();
        check("xp_rvalid0", 32'(rvalid_0), 32'd1);
        check("xp_rdata0",  rdata_0, 32'h12345678);

        // Port 1 load followed by store: only the load responds
        tick();
        req_1 = 1'b1; write_1 = 1'b0; addr_1 = 32'h20;
        mid();
        check("ls_gnt1_ld", 32'(gnt_1), 32'd1);
        tick();
        write_1 = 1'b1; addr_1 = 32'h24; wdata_1 = 32'hAAAA5555;
        mid();
        check("ls_rvalid1", 32'(rvalid_1), 32'd1);
        check("ls_rdata1",  rdata_1, 32'h12345678);
        check("ls_gnt1_st", 32'(gnt_1), 32'd1);
        tick();
        req_1 = 1'b0;
        mid();
        check("ls_norv1_st", 32'(rvalid_1), 32'd0);
        check("ls_rdata1_hold", rdata_1, 32'h12345678);

        // Reset asserted in the cycle after a load grant discards the response
        tick();
        req_0 = 1'b1; write_0 = 1'b0; addr_0 = 32'h10;
        mid();
        check("rml_gnt0", 32'(gnt_0), 32'd1);
        tick();
        req_0 = 1'b0;
        reset = 1'b1;
        mid();
        check("rml_rvalid0", 32'(rvalid_0), 32'd0);
        check("rml_rdata0",  rdata_0, 32'd0);
        tick();
        reset = 1'b0;
        mid();
        check("rml_post_rvalid0", 32'(rvalid_0), 32'd0);
        check("rml_post_rdata0",  rdata_0, 32'd0);
        check("rml_post_rdata1",  rdata_1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
